// File: rtl/lsu_pkg.sv
// Shared types, funct3 encodings and the legality rule for the load/store unit.
package lsu_pkg;

  localparam int NUM_LANES = 4;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    STORE_W,
    RMW_RD,
    RMW_WR,
    RESP
  } state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Stores have no unsigned variants; loads reject 011/110/111.
  function automatic logic is_legal(input logic we, input logic [2:0] funct3);
    if (we) return funct3 inside {F3_B, F3_H, F3_W};
    return funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
  endfunction

endpackage

// File: rtl/lsu_lane.sv
// Byte-lane datapath: load extract/extend and sub-word store merge.
module lsu_lane
  import lsu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] word,
  input  logic [DATA_W-1:0] wdata,
  input  logic [1:0]        off,
  input  logic [2:0]        funct3,
  output logic [DATA_W-1:0] ldata,
  output logic [DATA_W-1:0] mdata
);

  logic [NUM_LANES-1:0][7:0] wl, dl, ml;
  logic [7:0]                b;
  logic [15:0]               h;

  assign wl    = word;
  assign dl    = wdata;
  assign mdata = ml;
  assign b     = wl[off];
  assign h     = off[1] ? word[DATA_W-1 -: 16] : word[15:0];

  // Per lane: replace the byte when the access covers it, else keep the old byte.
  // A word store covers every lane, so the same path serves SW.
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    localparam logic HI = 1'((i / 2) % 2);
    logic       en;
    logic [7:0] nb;
    assign en    = (funct3[1:0] == 2'b00) ? (off == 2'(i)) :
                   (funct3[1:0] == 2'b01) ? (off[1] == HI) : 1'b1;
    assign nb    = (funct3[1:0] == 2'b00) ? dl[0] :
                   (funct3[1:0] == 2'b01) ? dl[i % 2] : dl[i];
    assign ml[i] = en ? nb : wl[i];
  end

  // Load result: signed variants replicate the top bit of the selected lane(s).
  always_comb begin
    ldata = word;
    case (funct3)
      F3_B:    ldata = {{(DATA_W-8){b[7]}}, b};
      F3_BU:   ldata = {{(DATA_W-8){1'b0}}, b};
      F3_H:    ldata = {{(DATA_W-16){h[15]}}, h};
      F3_HU:   ldata = {{(DATA_W-16){1'b0}}, h};
      default: ldata = word;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store control FSM between the MEM pipeline register and word-wide datamemory.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MEM_WORDS = 4198
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [ADDR_W-1:0] WORDS = ADDR_W'(MEM_WORDS);

  state_e            state, nxt;
  logic              r_we, r_err;
  logic [2:0]        r_f3;
  logic [ADDR_W-1:0] r_addr, widx;
  logic [DATA_W-1:0] r_wdata, r_word;
  logic              acc, mis, err, mw;
  logic [DATA_W-1:0] ldata, mdata;

  assign req_ready = (state == IDLE) && !rst;
  assign acc       = req_valid && req_ready;
  assign widx      = {2'b00, req_addr[ADDR_W-1:2]};
  assign mem_addr  = {2'b00, r_addr[ADDR_W-1:2]};
  assign mem_wdata = mdata;
  assign mem_write = mw && !rst;

  // Alignment follows the access size encoded in funct3[1:0].
  always_comb begin
    mis = 1'b0;
    case (req_funct3[1:0])
      2'b01:   mis = req_addr[0];
      2'b10:   mis = |req_addr[1:0];
      default: mis = 1'b0;
    endcase
  end

  // Full-width word-index compare so huge addresses cannot wrap into range.
  assign err = !is_legal(req_we, req_funct3) || mis || (widx >= WORDS);

  lsu_lane #(.DATA_W(DATA_W)) u_lane (
    .word   (r_word),
    .wdata  (r_wdata),
    .off    (r_addr[1:0]),
    .funct3 (r_f3),
    .ldata  (ldata),
    .mdata  (mdata)
  );

  // State register, request latch, and capture of the word read from datamemory.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      r_we    <= 1'b0;
      r_err   <= 1'b0;
      r_f3    <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_word  <= '0;
    end else begin
      state <= nxt;
      if (acc) begin
        r_we    <= req_we;
        r_err   <= err;
        r_f3    <= req_funct3;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
      end
      if (mem_read) r_word <= mem_rdata;
    end
  end

  // Next state and per-state strobes; rejected accesses go straight to RESP.
  always_comb begin
    nxt        = state;
    mem_read   = 1'b0;
    mw         = 1'b0;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    resp_rdata = '0;
    case (state)
      IDLE: begin
        if (acc) begin
          if (err)                     nxt = RESP;
          else if (!req_we)            nxt = LOAD;
          else if (req_funct3 == F3_W) nxt = STORE_W;
          else                         nxt = RMW_RD;
        end
      end
      LOAD: begin
        mem_read = 1'b1;
        nxt      = RESP;
      end
      STORE_W: begin
        mw  = 1'b1;
        nxt = RESP;
      end
      RMW_RD: begin
        mem_read = 1'b1;
        nxt      = RMW_WR;
      end
      RMW_WR: begin
        mw  = 1'b1;
        nxt = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_err   = r_err;
        resp_rdata = (r_we || r_err) ? '0 : ldata;
        nxt        = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: word-wide datamemory model plus an arithmetic reference of RV32I load/store rules.
module tb_lsu_ctrl;
  localparam int MW = 4198;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_we = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, resp_valid, resp_err, mem_read, mem_write;
  logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;

  int total = 0, bad = 0;
  int rw_viol = 0;
  logic        mem_init = 1'b1;
  logic [31:0] mem [MW];
  logic [31:0] ref_mem [MW];

  always #5 clk = ~clk;

  lsu_ctrl #(.ADDR_W(32), .DATA_W(32), .MEM_WORDS(MW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata));

  assign mem_rdata = (mem_addr < 32'(MW)) ? mem[mem_addr[12:0]] : 32'h0;

  // datamemory: preset to 0xAAAAAAAA, then plain word writes on MemWrite
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < MW; i++) mem[i] <= 32'hAAAA_AAAA;
    end else if (mem_write && mem_addr < 32'(MW)) begin
      mem[mem_addr[12:0]] <= mem_wdata;
    end
  end

  always @(negedge clk) if (mem_read && mem_write) rw_viol <= rw_viol + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: expected outcome from the RV32I rules; also commits stores to ref_mem.
  task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, output logic err, output logic [31:0] rdata,
                       output int lat, output int nwr, output int nrd);
    bit      legal;
    int      size, sh, idx;
    longint  w, v, mask;
    legal = we ? (f3 <= 3'd2) : (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
    size  = 1 << (f3 % 4);
    err   = !legal || (addr % size != 0) || ((addr / 4) >= MW);
    rdata = 32'h0;
    nwr   = 0;
    nrd   = 0;
    lat   = 1;
    if (err) return;
    idx = int'(addr / 4);
    sh  = int'(addr % 4) * 8;
    w   = longint'(ref_mem[idx]);
    if (!we) begin
      lat = 2; nrd = 1;
      v = (w >> sh) & ((64'd1 << (8 * size)) - 1);
      if (f3 < 4 && size < 4 && v >= (64'd1 << (8 * size - 1))) v = v - (64'd1 << (8 * size));
      rdata = v[31:0];
    end else begin
      nwr = 1;
      lat = (size == 4) ? 2 : 3;
      nrd = (size == 4) ? 0 : 1;
      mask = ((64'd1 << (8 * size)) - 1) << sh;
      v = (w & ~mask) | ((longint'(wd) << sh) & mask);
      ref_mem[idx] = v[31:0];
    end
  endtask

  // One isolated access with latency, strobe and response checks.
  task automatic acc(input string tag, input logic we, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [31:0] wd);
    logic        e, got, gerr;
    logic [31:0] rd, grd;
    int          lat, nwr, nrd, n, k, wr, rdc, abad, bbad;
    model(we, f3, addr, wd, e, rd, lat, nwr, nrd);
    @(negedge clk);
    req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    chk({tag, "_rdy"}, {31'b0, req_ready}, 32'd1);
    @(posedge clk); #1 req_valid = 1'b0;
    k = 0; got = 0; wr = 0; rdc = 0; abad = 0; bbad = 0; grd = '0; gerr = 0;
    while (!got && k < 10) begin
      @(negedge clk); k++;
      if (mem_write) wr++;
      if (mem_read) rdc++;
      if (mem_addr != (addr >> 2)) abad++;
      if (resp_valid) begin got = 1; grd = resp_rdata; gerr = resp_err; end
      else if (req_ready) bbad++;
    end
    chk({tag, "_lat"}, 32'(k), 32'(lat));
    chk({tag, "_err"}, {31'b0, gerr}, {31'b0, e});
    chk({tag, "_rdata"}, grd, rd);
    chk({tag, "_nwr"}, 32'(wr), 32'(nwr));
    chk({tag, "_nrd"}, 32'(rdc), 32'(nrd));
    chk({tag, "_addr"}, 32'(abad), 32'd0);
    chk({tag, "_busy"}, 32'(bbad), 32'd0);
    @(negedge clk);
    chk({tag, "_pulse"}, {31'b0, resp_valid}, 32'd0);
    chk({tag, "_idle"}, {31'b0, req_ready}, 32'd1);
  endtask

  logic [31:0] b2b_q[$];
  int          b2b_n = 0;

  task automatic tick();
    @(negedge clk);
    if (resp_valid) begin
      b2b_n++;
      if (b2b_q.size() == 0) chk("b2b_extra", 32'd1, 32'd0);
      else chk("b2b_rdata", resp_rdata, b2b_q.pop_front());
    end
  endtask

  initial begin
    logic        e;
    logic [31:0] rd;
    int          lat, nwr, nrd, n, k, rv, wv;
    logic        bw [3];
    logic [2:0]  bf [3];
    logic [31:0] bd [3];

    for (int i = 0; i < MW; i++) ref_mem[i] = 32'hAAAA_AAAA;
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'b0, req_ready}, 32'd0);
    chk("rst_resp", {30'b0, resp_valid, resp_err}, 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_mem", {30'b0, mem_read, mem_write}, 32'd0);
    rst = 1'b0; mem_init = 1'b0;
    @(negedge clk);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_rel_ready", {31'b0, req_ready}, 32'd1);

    acc("lb1",  1'b0, 3'b000, 32'h1, 32'h0);
    acc("lbu1", 1'b0, 3'b100, 32'h1, 32'h0);
    acc("lhu2", 1'b0, 3'b101, 32'h2, 32'h0);
    acc("sb6",  1'b1, 3'b000, 32'h6, 32'h1234_5678);
    acc("lw4",  1'b0, 3'b010, 32'h4, 32'h0);
    chk("sb6_word", mem[1], 32'hAA78_AAAA);
    acc("sw8",  1'b1, 3'b010, 32'h8, 32'hDEAD_BEEF);
    acc("lha",  1'b0, 3'b001, 32'hA, 32'h0);
    acc("lh8",  1'b0, 3'b001, 32'h8, 32'h0);
    acc("sh3",  1'b1, 3'b001, 32'h3, 32'hFFFF);
    acc("lw2",  1'b0, 3'b010, 32'h2, 32'h0);
    acc("ld011", 1'b0, 3'b011, 32'h0, 32'h0);
    acc("st100", 1'b1, 3'b100, 32'h0, 32'h0);
    acc("lwoor", 1'b0, 3'b010, 32'h4198, 32'h0);
    acc("lwlast", 1'b0, 3'b010, 32'h4194, 32'h0);
    acc("lwhuge", 1'b0, 3'b010, 32'hFFFF_FFFC, 32'h0);
    chk("err_w0", mem[0], 32'hAAAA_AAAA);

    // Reset during RMW_WR of SH 0x0; a held request must wait for rst release.
    @(negedge clk);
    req_we = 1'b1; req_funct3 = 3'b001; req_addr = 32'h0; req_wdata = 32'h1111; req_valid = 1'b1;
    @(posedge clk); #1;
    req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h0; req_wdata = 32'h0;
    @(negedge clk);
    chk("rmw_rd", {30'b0, mem_read, mem_write}, 32'd2);
    @(negedge clk);
    chk("rmw_wr", {30'b0, mem_read, mem_write}, 32'd1);
    rst = 1'b1; #1;
    chk("rst_gate_wr", {31'b0, mem_write}, 32'd0);
    rv = 0; wv = 0;
    repeat (2) begin
      @(negedge clk);
      if (resp_valid) rv++;
      if (mem_write) wv++;
      chk("rst_hold_ready", {31'b0, req_ready}, 32'd0);
    end
    chk("rst_no_resp", 32'(rv), 32'd0);
    chk("rst_no_wr", 32'(wv), 32'd0);
    chk("rst_w0", mem[0], 32'hAAAA_AAAA);
    rst = 1'b0; #1;
    chk("rst_idle", {31'b0, req_ready}, 32'd1);
    model(1'b0, 3'b010, 32'h0, 32'h0, e, rd, lat, nwr, nrd);
    @(posedge clk); #1 req_valid = 1'b0;
    k = 0; n = 0;
    while (n == 0 && k < 10) begin @(negedge clk); k++; if (resp_valid) n = 1; end
    chk("post_rst_lat", 32'(k), 32'(lat));
    chk("post_rst_rdata", resp_rdata, rd);

    // Back-to-back with req_valid held high: LW, SB, LW all at 0x10.
    bw[0] = 1'b0; bf[0] = 3'b010; bd[0] = 32'h0;
    bw[1] = 1'b1; bf[1] = 3'b000; bd[1] = 32'h0000_00C3;
    bw[2] = 1'b0; bf[2] = 3'b010; bd[2] = 32'h0;
    tick();
    req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req_we = bw[i]; req_funct3 = bf[i]; req_addr = 32'h10; req_wdata = bd[i];
      model(bw[i], bf[i], 32'h10, bd[i], e, rd, lat, nwr, nrd);
      b2b_q.push_back(rd);
      n = 0;
      while (!req_ready && n < 20) begin tick(); n++; end
      chk("b2b_rdy", {31'b0, req_ready}, 32'd1);
      tick();
      chk("b2b_busy", {31'b0, req_ready}, 32'd0);
    end
    req_valid = 1'b0;
    repeat (6) tick();
    chk("b2b_count", 32'(b2b_n), 32'd3);
    chk("b2b_final", ref_mem[4], 32'hAAAA_AAC3);

    // Random mix, mostly in a small window so stores and loads overlap.
    for (int i = 0; i < 150; i++) begin
      logic [31:0] a;
      k = int'($urandom_range(0, 9));
      if (k == 0)      a = 32'(4 * MW) + $urandom_range(0, 7);
      else if (k == 1) a = $urandom;
      else             a = $urandom_range(0, 63);
      acc("rnd", 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom);
    end
    for (int i = 0; i < 16; i++) chk("rnd_mem", mem[i], ref_mem[i]);
    chk("rw_excl", 32'(rw_viol), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
